instr_fetch_unit: RTL
=====================

// Module: instr_fetch_unit
// PURPOSE
//  Producer end of the decoder's instruction interface. Holds the PC and fetches 32-bit words
//  from instruction memory over a req/ack handshake. Presents each word to the instruction
//  decoder through a one-entry instruction register (valid/ready).
//  Consumes the decoder's PC_MUX_Select, the branch outcome and the register value to pick the next PC.
// PARAMETERS
//  RESET_PC  32'h0000_0000  first fetch address after reset (bits[1:0] must be 00)
// PORTS
//  clk            in   1   single clock, all state updates on rising edge
//  rst            in   1   synchronous, active-high reset
//  imem_req       out  1   fetch request; held with imem_addr until imem_ack
//  imem_addr      out  32  word address of the outstanding fetch
//  imem_ack       in   1   memory returns imem_rdata this cycle (may be the same cycle as req)
//  imem_rdata     in   32  fetched word, valid only when imem_ack=1
//  instr          out  32  instruction word to the decoder
//  instr_pc       out  32  address of instr
//  instr_valid    out  1   instr/instr_pc valid
//  instr_ready    in   1   decoder consumes instr this cycle (when instr_valid=1)
//  PC_MUX_Select  in   2   next-PC select for the consumed instr: 00 seq, 01 branch, 10 jump, 11 reg
//  branch_taken   in   1   branch condition result; sampled only with PC_MUX_Select=01
//  rs_data        in   32  register target for PC_MUX_Select=11
//  flush          in   1   redirect request (exception/restart); highest priority after rst
//  flush_pc       in   32  redirect target
// BEHAVIOUR
//  - Reset (rst=1 at an edge): state<=FETCH; fetch_pc<=RESET_PC; instr<=0; instr_pc<=0; instr_valid<=0.
//    While rst=1, imem_req=0 and imem_addr=RESET_PC. An outstanding fetch is abandoned.
//  - States: FETCH (imem_req=1, imem_addr=fetch_pc); FULL (instr_valid=1, imem_req=0);
//    DRAIN (imem_req=1 at the squashed address, result discarded).
//  - FETCH & imem_ack & !flush -> load instr<=imem_rdata, instr_pc<=fetch_pc, go FULL.
//    Minimum issue interval is 2 cycles per instruction; one fetch is outstanding at most.
//  - FULL & instr_ready & !flush -> fetch_pc<=next_pc, instr_valid<=0, go FETCH.
//    With instr_ready=0, instr and instr_pc stay bit-stable.
//  - next_pc (all arithmetic mod 2^32, pc4 = instr_pc+4):
//    00 -> pc4.
//    01 -> pc4 + {{14{instr[15]}},instr[15:0],2'b00} if branch_taken, else pc4.
//    10 -> {pc4[31:28],instr[25:0],2'b00}.
//    11 -> {rs_data[31:2],2'b00}.
//  - flush (overrides instr_ready):
//    FULL -> instr_valid<=0, fetch_pc<=flush_pc, go FETCH.
//    FETCH with imem_ack in the same cycle -> data dropped, fetch_pc<=flush_pc, stay FETCH.
//    FETCH without ack -> pend_pc<=flush_pc, go DRAIN.
//    DRAIN: req/addr held; on ack, data dropped, fetch_pc<=pend_pc, go FETCH.
//    A new flush in DRAIN overwrites pend_pc (last one wins).
//  - flush_pc bits[1:0] are forced to 00.
//  - fetch_pc 32'hFFFF_FFFC advances sequentially to 32'h0000_0000.
//  - imem_addr and imem_req never change while a request is unacknowledged, except by rst.
// STRUCTURE
//  - Package ifu_pkg holds:
//    - PC_SEL_SEQ/BR/JMP/REG localparams (2'b00..2'b11) shared with the decoder
//    - fetch state encoding (FETCH/FULL/DRAIN)
//    - INSTR_W=32
//  - Sub-module pc_next_calc: purely combinational.
//    Inputs: instr, instr_pc, PC_MUX_Select, branch_taken, rs_data. Output: next_pc.
//  - Top level contains the FSM, fetch_pc/pend_pc and the instruction register.
// TESTING
//  1 Reset, memory acks same cycle with 0x11,0x22,0x33, instr_ready=1
//    -> imem_addr 0x0,0x4,0x8; instr_valid every 2nd cycle with the matching instr_pc.
//  2 instr_pc=0x10, instr[15:0]=0x0003, sel=01:
//    taken=1 -> next addr 0x20; taken=0 -> 0x14; imm=0xFFFF, taken=1 -> 0x10.
//  3 instr_pc=0x1000_0040, instr[25:0]=0x9, sel=10 -> next addr 0x1000_0024.
//    sel=11, rs_data=0x0000_0103 -> 0x0000_0100.
//  4 instr_ready=0 for 5 cycles in FULL -> instr/instr_pc unchanged, imem_req=0 throughout.
//  5 ack latency 3, flush with flush_pc=0x80 one cycle after req
//    -> req/addr held until ack; that word never raises instr_valid; next imem_addr=0x80.
//    Second flush 0x90 during DRAIN -> next imem_addr=0x90.
//  6 RESET_PC=0xFFFF_FFFC -> fetches 0xFFFF_FFFC then 0x0.
//    rst asserted mid-DRAIN -> next cycle FETCH at RESET_PC, instr_valid=0.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit and the decoder side
// of the instruction interface: next-PC select codes, fetch FSM encoding
// and the instruction word width.
package ifu_pkg;

  localparam int INSTR_W = 32;

  // Next-PC select codes driven by the decoder for the consumed instruction
  localparam logic [1:0] PC_SEL_SEQ = 2'b00;
  localparam logic [1:0] PC_SEL_BR  = 2'b01;
  localparam logic [1:0] PC_SEL_JMP = 2'b10;
  localparam logic [1:0] PC_SEL_REG = 2'b11;

  // Fetch FSM encoding
  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t ST_FETCH = 2'b00;
  localparam fetch_state_t ST_FULL  = 2'b01;
  localparam fetch_state_t ST_DRAIN = 2'b10;

  // Instruction addresses are always word aligned; low two bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection for the instruction currently held in
// the instruction register. All arithmetic wraps modulo 2^32.
module pc_next_calc
  import ifu_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  input  logic [31:0]        instr_pc,
  input  logic [1:0]         PC_MUX_Select,
  input  logic               branch_taken,
  input  logic [31:0]        rs_data,
  output logic [31:0]        next_pc
);

  logic [31:0] pc4;
  logic [31:0] br_off;
  logic        unused_opcode;

  // Opcode bits above the jump target field do not affect the next PC.
  assign unused_opcode = ^instr[31:26];

  // Pick the next fetch address from the decoder's select and branch outcome
  always_comb begin
    pc4     = instr_pc + 32'd4;
    br_off  = {{14{instr[15]}}, instr[15:0], 2'b00};
    next_pc = pc4;
    case (PC_MUX_Select)
      PC_SEL_SEQ: next_pc = pc4;
      PC_SEL_BR:  if (branch_taken) next_pc = pc4 + br_off;
      PC_SEL_JMP: next_pc = {pc4[31:28], instr[25:0], 2'b00};
      PC_SEL_REG: next_pc = word_align(rs_data);
      default:    next_pc = pc4;
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches words from instruction
// memory over req/ack and hands them to the decoder through a one-entry
// instruction register with valid/ready.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_FETCH | request outstanding at fetch_pc, instruction register empty
//   ST_FULL  | instruction register holds a word for the decoder, no request
//   ST_DRAIN | squashed request still outstanding; its data is discarded and
//            | fetching resumes at pend_pc once memory acknowledges
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ack,
  input  logic [31:0]        imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic [31:0]        instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic [1:0]         PC_MUX_Select,
  input  logic               branch_taken,
  input  logic [31:0]        rs_data,
  input  logic               flush,
  input  logic [31:0]        flush_pc
);

  fetch_state_t state;
  logic [31:0]  fetch_pc;
  logic [31:0]  pend_pc;
  logic [31:0]  next_pc;
  logic [31:0]  flush_tgt;

  assign flush_tgt = word_align(flush_pc);

  pc_next_calc u_pc_next_calc (
    .instr         (instr),
    .instr_pc      (instr_pc),
    .PC_MUX_Select (PC_MUX_Select),
    .branch_taken  (branch_taken),
    .rs_data       (rs_data),
    .next_pc       (next_pc)
  );

  // fetch_pc is untouched while draining, so the squashed request keeps
  // its address until memory acknowledges it.
  assign imem_req    = !rst && ((state == ST_FETCH) || (state == ST_DRAIN));
  assign imem_addr   = rst ? RESET_PC : fetch_pc;
  assign instr_valid = (state == ST_FULL);

  // Fetch FSM, PC registers and instruction register
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_FETCH;
      fetch_pc <= RESET_PC;
      pend_pc  <= RESET_PC;
      instr    <= '0;
      instr_pc <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (flush) begin
            if (imem_ack) begin
              fetch_pc <= flush_tgt;
            end else begin
              pend_pc <= flush_tgt;
              state   <= ST_DRAIN;
            end
          end else if (imem_ack) begin
            instr    <= imem_rdata;
            instr_pc <= fetch_pc;
            state    <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (flush) begin
            fetch_pc <= flush_tgt;
            state    <= ST_FETCH;
          end else if (instr_ready) begin
            fetch_pc <= next_pc;
            state    <= ST_FETCH;
          end
        end
        ST_DRAIN: begin
          // A flush arriving with the ack is the most recent redirect.
          if (imem_ack) begin
            fetch_pc <= flush ? flush_tgt : pend_pc;
            state    <= ST_FETCH;
          end else if (flush) begin
            pend_pc <= flush_tgt;
          end
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

endmodule
